// File: rtl/pc_unit.sv
// pc_unit: MIPS program counter with one architectural delay slot and halt-on-HALT_ADDR detection
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  output logic [31:0] instr_address,
  output logic        active,
  output logic        in_delay_slot,
  output logic        pc_fault
);
  typedef enum logic [1:0] {RUN, DELAY, HALTED} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_q, pend_d, pc4, tgt;
  logic ds_q, ds_d, act_q, act_d, fault_q, fault_d, xfer;
  assign pc4  = pc_q + 32'd4;
  assign xfer = jump_reg | jump | branch;
  assign tgt  = jump_reg ? {jump_reg_target[31:2], 2'b00}
              : jump     ? {pc4[31:28], jump_index, 2'b00}
              :            pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ds_d    = ds_q;
    act_d   = act_q;
    fault_d = fault_q;
    if (!stall) begin
      case (state_q)
        RUN: begin
          pc_d = pc4;
          if (xfer) begin
            pend_d  = tgt;
            ds_d    = 1'b1;
            state_d = DELAY;
          end
          if (jump_reg && jump_reg_target[1:0] != 2'b00) fault_d = 1'b1;
        end
        DELAY: begin
          ds_d    = 1'b0;
          pc_d    = pend_q;
          act_d   = pend_q != HALT_ADDR;
          state_d = (pend_q == HALT_ADDR) ? HALTED : RUN;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 32'd0;
      ds_q    <= 1'b0;
      act_q   <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ds_q    <= ds_d;
      act_q   <= act_d;
      fault_q <= fault_d;
    end
  end
  assign instr_address = pc_q;
  assign active        = act_q;
  assign in_delay_slot = ds_q;
  assign pc_fault      = fault_q;
endmodule
